// File: rtl/am2950_port_pkg.sv
// -----------------------------------------------------------------------------
// am2950_port_pkg
// Shared definitions for the am2950 handshaked I/O port:
//   ASSERTED_ / NEGATED_ : levels of the active-low control and status pins
//   AM2950_WIDTH         : default data width of both channels
// -----------------------------------------------------------------------------
package am2950_port_pkg;

  localparam logic ASSERTED_    = 1'b0;
  localparam logic NEGATED_     = 1'b1;
  localparam int   AM2950_WIDTH = 8;

endpackage

// File: rtl/am2950_port_chan.sv
// -----------------------------------------------------------------------------
// am2950_chan
// One transfer channel of the am2950 port: a holding register, a full flag,
// an optional sticky overrun flag and a tristate output driver.
// Optional feature macro: AM2950_OVR_EN (enables overrun storage).
// Ports:
//   clk   in   clock, rising edge active
//   rst_  in   asynchronous reset, active low
//   d     in   WIDTH data to load
//   ld_   in   load holding register from d, set full (active low)
//   ack_  in   acknowledge, clears full (active low); load wins over ack
//   oe_   in   drive y (active low)
//   y     out  WIDTH register contents when oe_=0, else high impedance
//   full  out  full flag
//   ovr   out  overrun flag (0 when AM2950_OVR_EN is undefined)
// -----------------------------------------------------------------------------
module am2950_chan
  import am2950_port_pkg::*;
#(
  parameter int WIDTH = AM2950_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] d,
  input  logic             ld_,
  input  logic             ack_,
  input  logic             oe_,
  output logic [WIDTH-1:0] y,
  output logic             full,
  output logic             ovr
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // A load overrides a simultaneous ack: the new data is pending, so full
  // must stay set and the ack is discarded.
  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ASSERTED_) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (ld_ == ASSERTED_) begin
      r_data <= d;
      r_full <= 1'b1;
    end else if (ack_ == ASSERTED_) begin
      r_full <= 1'b0;
    end
  end

`ifdef AM2950_OVR_EN
  logic r_ovr;

  // Overrun marks a load that overwrote unacknowledged data. Any ack edge
  // of this channel clears it, including one that coincides with a load.
  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ASSERTED_) begin
      r_ovr <= 1'b0;
    end else if (ack_ == ASSERTED_) begin
      r_ovr <= 1'b0;
    end else if ((ld_ == ASSERTED_) && r_full) begin
      r_ovr <= 1'b1;
    end
  end

  assign ovr = r_ovr;
`else
  assign ovr = 1'b0;
`endif

  assign full = r_full;
  assign y    = (oe_ == ASSERTED_) ? r_data : {WIDTH{1'bz}};

endmodule

// File: rtl/am2950_port.sv
// -----------------------------------------------------------------------------
// am2950_port
// Synchronous bidirectional handshaked I/O port in the style of the Am2950.
// S channel: CPU (A side) -> peripheral (B side).
// R channel: peripheral (B side) -> CPU (A side).
// Optional feature macro: AM2950_OVR_EN (sticky overrun flags ovs/ovr).
// Ports:
//   clk          clock, rising edge active
//   rst_         asynchronous reset, active low
//   a_d, lds_    CPU data / load S (active low)
//   ackr_        CPU acknowledge of R data (active low)
//   oea_, a_y    drive enable (active low) / R register output (tristate)
//   b_d, ldr_    peripheral data / load R (active low)
//   acks_        peripheral acknowledge of S data (active low)
//   oeb_, b_y    drive enable (active low) / S register output (tristate)
//   ie           interrupt enable
//   fs, fr       S / R full flags
//   irq_         active-low interrupt, asserted while fr=1 and ie=1
//   ovs, ovr     S / R overrun flags (0 without AM2950_OVR_EN)
// -----------------------------------------------------------------------------
module am2950_port
  import am2950_port_pkg::*;
#(
  parameter int WIDTH = AM2950_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] a_d,
  input  logic             lds_,
  input  logic             ackr_,
  input  logic             oea_,
  output logic [WIDTH-1:0] a_y,
  input  logic [WIDTH-1:0] b_d,
  input  logic             ldr_,
  input  logic             acks_,
  input  logic             oeb_,
  output logic [WIDTH-1:0] b_y,
  input  logic             ie,
  output logic             fs,
  output logic             fr,
  output logic             irq_,
  output logic             ovs,
  output logic             ovr
);

  logic w_fr;

  am2950_chan #(.WIDTH(WIDTH)) u_s_chan (
    .clk  (clk),
    .rst_ (rst_),
    .d    (a_d),
    .ld_  (lds_),
    .ack_ (acks_),
    .oe_  (oeb_),
    .y    (b_y),
    .full (fs),
    .ovr  (ovs)
  );

  am2950_chan #(.WIDTH(WIDTH)) u_r_chan (
    .clk  (clk),
    .rst_ (rst_),
    .d    (b_d),
    .ld_  (ldr_),
    .ack_ (ackr_),
    .oe_  (oea_),
    .y    (a_y),
    .full (w_fr),
    .ovr  (ovr)
  );

  assign fr = w_fr;

  // Combinational so that dropping ie releases the interrupt immediately.
  assign irq_ = (w_fr && ie) ? ASSERTED_ : NEGATED_;

endmodule

// File: tb/tb_am2950_port.sv
module tb_am2950_port;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] a_d, b_d;
  logic       lds_, ackr_, oea_, ldr_, acks_, oeb_, ie;
  wire  [7:0] a_y, b_y;
  wire        fs, fr, irq_, ovs, ovr;

  am2950_port #(.WIDTH(8)) dut (
    .clk(clk), .rst_(rst_), .a_d(a_d), .lds_(lds_), .ackr_(ackr_),
    .oea_(oea_), .a_y(a_y), .b_d(b_d), .ldr_(ldr_), .acks_(acks_),
    .oeb_(oeb_), .b_y(b_y), .ie(ie), .fs(fs), .fr(fr), .irq_(irq_),
    .ovs(ovs), .ovr(ovr)
  );

  always #5 clk = ~clk;

`ifdef AM2950_OVR_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  // kind: 0 b_y, 1 a_y, 2 fs, 3 fr, 4 irq_, 5 ovs, 6 ovr, 7 a_y high-Z
  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_done = 0;

  task automatic expect_v(input int kind, input logic [7:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic present();
    -> sample_ev;
    #1;
  endtask

  // Monitor: whenever the stimulus presents a settled output state, pop every
  // queued expectation and compare against the live DUT pins.
  initial begin
    exp_t       e;
    logic [7:0] act;
    bit         ok;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = 8'h00;
        case (e.kind)
          0: act = b_y;
          1: act = a_y;
          2: act = {7'b0, fs};
          3: act = {7'b0, fr};
          4: act = {7'b0, irq_};
          5: act = {7'b0, ovs};
          6: act = {7'b0, ovr};
          default: act = a_y;
        endcase
        if (e.kind == 7) ok = (a_y === 8'bzzzzzzzz);
        else             ok = (act === e.exp);
        n_tests++;
        if (!ok) begin
          n_fail++;
          if (e.kind == 7)
            $display("FAIL %s: got %b, required zzzzzzzz", e.name, act);
          else
            $display("FAIL %s: got %b, required %b", e.name, act, e.exp);
        end
      end
    end
  end

  // One clock edge with the given controls held low, then back to idle.
  task automatic cycle(input logic l_s, input logic a_s, input logic l_r, input logic a_r);
    @(negedge clk);
    lds_ = l_s; acks_ = a_s; ldr_ = l_r; ackr_ = a_r;
    @(posedge clk);
    #2;
    lds_ = 1'b1; acks_ = 1'b1; ldr_ = 1'b1; ackr_ = 1'b1;
  endtask

  initial begin
    rst_ = 1'b0; a_d = 8'h00; b_d = 8'h00;
    lds_ = 1'b1; acks_ = 1'b1; ldr_ = 1'b1; ackr_ = 1'b1;
    oea_ = 1'b0; oeb_ = 1'b0; ie = 1'b1;

    // Reset state, sampled before the first rising edge (t=5).
    #2;
    expect_v(0, 8'h00, "rst_b_y");
    expect_v(1, 8'h00, "rst_a_y");
    expect_v(2, 8'h00, "rst_fs");
    expect_v(3, 8'h00, "rst_fr");
    expect_v(4, 8'h01, "rst_irq");
    expect_v(5, 8'h00, "rst_ovs");
    expect_v(6, 8'h00, "rst_ovr");
    present();
    rst_ = 1'b1;
    ie = 1'b0;

    // CPU -> peripheral
    a_d = 8'hA5;
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    expect_v(0, 8'hA5, "load_s_b_y");
    expect_v(2, 8'h01, "load_s_fs");
    present();
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    expect_v(2, 8'h00, "ack_s_fs");
    expect_v(0, 8'hA5, "ack_s_b_y_kept");
    present();

    // Peripheral -> CPU with interrupt
    ie = 1'b1; b_d = 8'h3C;
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    expect_v(3, 8'h01, "load_r_fr");
    expect_v(4, 8'h00, "load_r_irq");
    expect_v(1, 8'h3C, "load_r_a_y");
    present();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    expect_v(3, 8'h00, "ack_r_fr");
    expect_v(4, 8'h01, "ack_r_irq");
    expect_v(1, 8'h3C, "ack_r_a_y_kept");
    present();
    oea_ = 1'b1;
    #1;
    expect_v(7, 8'h00, "a_y_hiz");
    present();

    // ie gating of irq_ is combinational
    b_d = 8'h81;
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    expect_v(4, 8'h00, "irq_set_again");
    present();
    ie = 1'b0;
    #1;
    expect_v(4, 8'h01, "irq_ie_off");
    present();
    ie = 1'b1;
    #1;
    expect_v(4, 8'h00, "irq_ie_on");
    present();
    oea_ = 1'b0;

    // Simultaneous load and ack: load wins
    a_d = 8'h55;
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    a_d = 8'hF0;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    expect_v(2, 8'h01, "simul_fs");
    expect_v(0, 8'hF0, "simul_b_y");
    expect_v(5, 8'h00, "simul_ovs");
    present();

    // Overrun on S (fs=1) and on R (fr=1 from the 0x81 load)
    a_d = 8'h0F; b_d = 8'h99;
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    expect_v(0, 8'h0F, "ovr_s_b_y");
    expect_v(5, {7'b0, OVR_ON}, "ovr_s_ovs");
    expect_v(1, 8'h99, "ovr_r_a_y");
    expect_v(6, {7'b0, OVR_ON}, "ovr_r_ovr");
    present();
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    expect_v(2, 8'h00, "ovr_ack_fs");
    expect_v(5, 8'h00, "ovr_ack_ovs");
    expect_v(6, {7'b0, OVR_ON}, "ovr_r_sticky");
    present();

    // All four controls in one cycle; ackr clears ovr, loads win on both sides
    a_d = 8'h11; b_d = 8'h22;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(0, 8'h11, "all4_b_y");
    expect_v(1, 8'h22, "all4_a_y");
    expect_v(2, 8'h01, "all4_fs");
    expect_v(3, 8'h01, "all4_fr");
    expect_v(6, 8'h00, "all4_ovr");
    present();

    // Asynchronous reset mid-transfer, between edges
    @(negedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    expect_v(2, 8'h00, "arst_fs");
    expect_v(3, 8'h00, "arst_fr");
    expect_v(4, 8'h01, "arst_irq");
    expect_v(0, 8'h00, "arst_b_y");
    expect_v(1, 8'h00, "arst_a_y");
    present();
    rst_ = 1'b1;

    // First load after reset behaves normally
    a_d = 8'h7E;
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    expect_v(0, 8'h7E, "post_rst_b_y");
    expect_v(2, 8'h01, "post_rst_fs");
    expect_v(5, 8'h00, "post_rst_ovs");
    present();

    #5;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
